array_write_buffer: RTL and testbench
=====================================

ARRAY_WRITE_BUFFER -- requirements
Module: array_write_buffer

Interface
REQ-001 Parameter: AN, `addrN (8), address width.
REQ-002 Parameter: DN, `intN (8), data width.
REQ-003 Parameter: DEPTH, 4, write-queue entries; power of two, at least 2.
REQ-004 Port: clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous and active-high.
REQ-006 Port: up_valid / up_ready  in / out  1 / 1  upstream Array request handshake, fed by the compiled function's Array output.
REQ-007 Port: up_we / up_addr / up_di  in  1 / AN / DN  request kind (1 = write), address, write data.
REQ-008 Port: up_do / up_do_valid  out  DN / 1  read data, with a one-cycle valid pulse.
REQ-009 Port: dn_valid / dn_ready  out / in  1 / 1  downstream request handshake into the array memory.
REQ-010 Port: dn_we / dn_addr / dn_di  out  1 / AN / DN  downstream request fields.
REQ-011 Port: dn_do  in  DN  array read data; valid the cycle after an accepted downstream read.

Function
REQ-012 The block SHALL hold a FIFO of DEPTH {addr, data} write entries, with occupancy count 0..DEPTH.
REQ-013 The state machine SHALL have four states: IDLE, DRAIN, RD_REQ and RD_RESP.
REQ-014 up_ready SHALL be 1 only in IDLE with count < DEPTH; it SHALL NOT depend combinationally on dn_ready or up_*.
REQ-015 An upstream write (up_valid & up_ready & up_we) SHALL push {up_addr, up_di} at the tail.
REQ-016 In IDLE and DRAIN with count > 0: dn_valid = 1, dn_we = 1, dn_addr/dn_di = head entry.
REQ-017 The head entry SHALL be popped on dn_valid & dn_ready.
REQ-018 dn_* SHALL hold stable while dn_valid & !dn_ready.
REQ-019 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-020 Read hit: an upstream read (up_we = 0) whose address matches any queued entry SHALL forward the newest matching entry's data.
REQ-021 Read-hit timing: up_do loads the forwarded data and up_do_valid = 1 on the next cycle; the state stays IDLE.
REQ-022 A hit on the entry being popped in the same cycle SHALL still forward that entry's data.
REQ-023 Read miss: IDLE -> RD_REQ if count = 0, else IDLE -> DRAIN; the address is latched.
REQ-024 DRAIN SHALL continue popping writes and go to RD_REQ on the cycle count reaches 0.
REQ-025 RD_REQ: dn_valid = 1, dn_we = 0, dn_addr = latched address; on dn_ready go to RD_RESP.
REQ-026 RD_RESP: capture dn_do into up_do, pulse up_do_valid the next cycle, and return to IDLE.
REQ-027 Miss latency with an empty queue and dn_ready held at 1 SHALL be 3 cycles from acceptance to up_do_valid.
REQ-028 up_do SHALL hold its last value while up_do_valid = 0.
REQ-029 dn_valid = 0 in IDLE when count = 0, and always in RD_RESP.

Reset
REQ-030 While rst is 1 at a clock edge: count, pointers = 0; state = IDLE; up_do = 0; up_do_valid = 0; dn_valid = 0; up_ready = 0.
REQ-031 up_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard queued writes and any outstanding read; no up_do_valid pulse afterwards.

Verification
REQ-033 Writes (1,10), (2,20), (3,30) with dn_ready = 1 -> downstream writes arr[1]<=10, arr[2]<=20, arr[3]<=30, in order, each exactly once.
REQ-034 dn_ready = 0, writes (1,10), (2,20), read addr 2 -> up_do = 20 with up_do_valid one cycle later; no downstream read issued.
REQ-035 dn_ready = 0, five writes offered back-to-back -> up_ready falls after the 4th acceptance; the 5th is held until the first pop.
REQ-036 Writes (5,1), (5,2) queued, read addr 5 -> up_do = 2.
REQ-037 Array preloaded arr[7] = 77, two writes queued, read addr 7 -> both writes reach the array first, then a downstream read of addr 7, then up_do = 77.
REQ-038 Reset asserted in DRAIN with 2 entries queued -> count = 0 and state IDLE after the edge; no further dn_valid and no up_do_valid.

Source files
------------

// File: rtl/array_write_buffer.sv
// array_write_buffer: posted-write FIFO in front of an array memory, with read forwarding and drain-before-miss ordering
module array_write_buffer #(
    parameter int AN    = 8,
    parameter int DN    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic          up_we,
    input  logic [AN-1:0] up_addr,
    input  logic [DN-1:0] up_di,
    output logic [DN-1:0] up_do,
    output logic          up_do_valid,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic          dn_we,
    output logic [AN-1:0] dn_addr,
    output logic [DN-1:0] dn_di,
    input  logic [DN-1:0] dn_do
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RD_REQ, RD_RESP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AN-1:0] raddr_q, raddr_d;
    logic [DN-1:0] up_do_q, up_do_d;
    logic          up_do_valid_q, up_do_valid_d;
    logic [AN-1:0] addr_mem_q [DEPTH];
    logic [DN-1:0] data_mem_q [DEPTH];
    logic          push, pop, rd_acc, hit;
    logic [DN-1:0] hit_data;

    assign up_ready    = !rst && state_q == IDLE && count_q < CW'(DEPTH);
    assign up_do       = up_do_q;
    assign up_do_valid = up_do_valid_q;
    assign dn_valid    = ((state_q == IDLE || state_q == DRAIN) && count_q != '0) || state_q == RD_REQ;
    assign dn_we       = state_q != RD_REQ;
    assign dn_addr     = state_q == RD_REQ ? raddr_q : addr_mem_q[rd_ptr_q];
    assign dn_di       = data_mem_q[rd_ptr_q];
    assign push        = up_valid && up_ready && up_we;
    assign rd_acc      = up_valid && up_ready && !up_we;
    assign pop         = dn_valid && dn_ready && dn_we;

    // Scan head to tail so the last match (newest write) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && addr_mem_q[rd_ptr_q + PW'(i)] == up_addr) begin
                hit      = 1'b1;
                hit_data = data_mem_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        count_d       = count_q + CW'(push) - CW'(pop);
        state_d       = state_q;
        raddr_d       = raddr_q;
        up_do_d       = up_do_q;
        up_do_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_acc && hit) begin
                    up_do_d       = hit_data;
                    up_do_valid_d = 1'b1;
                end else if (rd_acc) begin
                    raddr_d = up_addr;
                    state_d = count_q == '0 ? RD_REQ : DRAIN;
                end
            end
            DRAIN:   state_d = count_d == '0 ? RD_REQ : DRAIN;
            RD_REQ:  state_d = dn_ready ? RD_RESP : RD_REQ;
            default: begin
                up_do_d       = dn_do;
                up_do_valid_d = 1'b1;
                state_d       = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            raddr_q       <= '0;
            up_do_q       <= '0;
            up_do_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            raddr_q       <= raddr_d;
            up_do_q       <= up_do_d;
            up_do_valid_q <= up_do_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= up_addr;
            data_mem_q[wr_ptr_q] <= up_di;
        end
    end
endmodule

// File: tb/tb_array_write_buffer.sv
// tb_array_write_buffer: directed scenarios plus random traffic against a sequential-memory reference model
module tb_array_write_buffer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       up_valid = 1'b0, up_ready, up_we = 1'b0, up_do_valid;
    logic [7:0] up_addr = '0, up_di = '0, up_do;
    logic       dn_valid, dn_ready = 1'b0, dn_we;
    logic [7:0] dn_addr, dn_di, dn_do = '0;
    int         checks = 0, errors = 0, up_acc = 0, vcnt = 0;
    logic [7:0] arr [256] = '{default: 8'h00};
    logic [16:0] ev_q [$];

    array_write_buffer #(.AN(8), .DN(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_we(up_we), .up_addr(up_addr), .up_di(up_di),
        .up_do(up_do), .up_do_valid(up_do_valid),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_we(dn_we), .dn_addr(dn_addr), .dn_di(dn_di),
        .dn_do(dn_do)
    );

    always #5 clk = ~clk;

    // Array memory responder and handshake logger.
    always @(posedge clk) begin
        if (!rst && dn_valid && dn_ready) begin
            ev_q.push_back({dn_we, dn_addr, dn_di});
            if (dn_we) arr[dn_addr] <= dn_di;
            else dn_do <= arr[dn_addr];
        end
        if (!rst && up_valid && up_ready) up_acc <= up_acc + 1;
        if (up_do_valid) vcnt <= vcnt + 1;
    end

    task automatic send(input logic we, input logic [7:0] a, input logic [7:0] d);
        up_valid = 1'b1; up_we = we; up_addr = a; up_di = d;
        for (int i = 0; i < 100 && !up_ready; i++) @(negedge clk);
        checks++;
        if (!up_ready) begin errors++; $display("FAIL send_timeout: up_ready got %b want 1", up_ready); end
        @(negedge clk);
        up_valid = 1'b0;
    endtask

    task automatic read(input logic [7:0] a, output logic [7:0] d, output int lat);
        send(1'b0, a, 8'h00);
        lat = 0;
        while (!up_do_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (!up_do_valid) begin errors++; $display("FAIL read_timeout addr %0d: up_do_valid got 0 want 1", a); end
        d = up_do;
    endtask

    task automatic wait_drain();
        dn_ready = 1'b1;
        for (int i = 0; i < 200 && dn_valid; i++) @(negedge clk);
        checks++;
        if (dn_valid) begin errors++; $display("FAIL drain_timeout: dn_valid got 1 want 0"); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 4;
        if (up_ready !== 1'b0) begin errors++; $display("FAIL reset_up_ready: got %b want 0", up_ready); end
        if (dn_valid !== 1'b0) begin errors++; $display("FAIL reset_dn_valid: got %b want 0", dn_valid); end
        if (up_do_valid !== 1'b0) begin errors++; $display("FAIL reset_up_do_valid: got %b want 0", up_do_valid); end
        if (up_do !== 8'h00) begin errors++; $display("FAIL reset_up_do: got %h want 00", up_do); end
        rst = 1'b0;
        #1;
        checks++;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL post_reset_up_ready: got %b want 1", up_ready); end
        @(negedge clk);
    endtask

    task automatic test_drain_order();
        logic [16:0] exp [3];
        int b;
        exp[0] = {1'b1, 8'd1, 8'd10}; exp[1] = {1'b1, 8'd2, 8'd20}; exp[2] = {1'b1, 8'd3, 8'd30};
        b = ev_q.size();
        dn_ready = 1'b1;
        send(1'b1, 8'd1, 8'd10); send(1'b1, 8'd2, 8'd20); send(1'b1, 8'd3, 8'd30);
        wait_drain();
        checks++;
        if (ev_q.size() - b != 3) begin errors++; $display("FAIL drain_count: got %0d want 3", ev_q.size() - b); end
        for (int i = 0; i < 3 && b + i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[b+i] !== exp[i]) begin errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, ev_q[b+i], exp[i]); end
        end
    endtask

    task automatic test_read_hit();
        logic [7:0] d;
        int lat, b, nrd;
        dn_ready = 1'b0;
        b = ev_q.size();
        send(1'b1, 8'd1, 8'd10); send(1'b1, 8'd2, 8'd20);
        read(8'd2, d, lat);
        checks += 2;
        if (d !== 8'd20) begin errors++; $display("FAIL hit_data: got %0d want 20", d); end
        if (lat != 0) begin errors++; $display("FAIL hit_latency: got %0d want 0", lat); end
        wait_drain();
        nrd = 0;
        for (int i = b; i < ev_q.size(); i++) if (!ev_q[i][16]) nrd++;
        checks++;
        if (nrd != 0) begin errors++; $display("FAIL hit_no_dn_read: got %0d reads want 0", nrd); end
    endtask

    task automatic test_newest();
        logic [7:0] d;
        int lat;
        dn_ready = 1'b0;
        send(1'b1, 8'd5, 8'd1); send(1'b1, 8'd5, 8'd2);
        read(8'd5, d, lat);
        checks += 2;
        if (d !== 8'd2) begin errors++; $display("FAIL newest_data: got %0d want 2", d); end
        if (lat != 0) begin errors++; $display("FAIL newest_latency: got %0d want 0", lat); end
        wait_drain();
        @(negedge clk);
        checks++;
        if (arr[5] !== 8'd2) begin errors++; $display("FAIL newest_array: got %0d want 2", arr[5]); end
    endtask

    task automatic test_full();
        int a0, b;
        dn_ready = 1'b0;
        a0 = up_acc;
        b = ev_q.size();
        for (int i = 0; i < 4; i++) send(1'b1, 8'(8 + i), 8'(40 + i));
        up_valid = 1'b1; up_we = 1'b1; up_addr = 8'd12; up_di = 8'd44;
        checks++;
        if (up_ready !== 1'b0) begin errors++; $display("FAIL full_up_ready: got %b want 0", up_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (up_acc - a0 != 4) begin errors++; $display("FAIL full_held: accepted %0d want 4", up_acc - a0); end
        dn_ready = 1'b1;
        @(negedge clk);
        checks += 2;
        if (ev_q.size() - b != 1) begin errors++; $display("FAIL full_first_pop: got %0d pops want 1", ev_q.size() - b); end
        if (up_acc - a0 != 4) begin errors++; $display("FAIL full_same_cycle: accepted %0d want 4", up_acc - a0); end
        @(negedge clk);
        up_valid = 1'b0;
        checks++;
        if (up_acc - a0 != 5) begin errors++; $display("FAIL full_fifth: accepted %0d want 5", up_acc - a0); end
        wait_drain();
        checks++;
        if (ev_q.size() - b != 5) begin errors++; $display("FAIL full_count: got %0d want 5", ev_q.size() - b); end
        for (int i = 0; i < 5 && b + i < ev_q.size(); i++) begin
            checks++;
            if (ev_q[b+i] !== {1'b1, 8'(8 + i), 8'(40 + i)})
                begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, ev_q[b+i], {1'b1, 8'(8 + i), 8'(40 + i)}); end
        end
    endtask

    task automatic test_miss_drain();
        logic [7:0] d;
        int lat, b;
        send(1'b1, 8'd7, 8'd77);
        wait_drain();
        dn_ready = 1'b0;
        send(1'b1, 8'd8, 8'd1); send(1'b1, 8'd9, 8'd2);
        b = ev_q.size();
        dn_ready = 1'b1;
        read(8'd7, d, lat);
        checks += 2;
        if (d !== 8'd77) begin errors++; $display("FAIL miss_data: got %0d want 77", d); end
        if (ev_q.size() - b != 3) begin errors++; $display("FAIL miss_events: got %0d want 3", ev_q.size() - b); end
        if (ev_q.size() - b == 3) begin
            checks += 3;
            if (ev_q[b] !== {1'b1, 8'd8, 8'd1}) begin errors++; $display("FAIL miss_ev0: got %h want 10801", ev_q[b]); end
            if (ev_q[b+1] !== {1'b1, 8'd9, 8'd2}) begin errors++; $display("FAIL miss_ev1: got %h want 10902", ev_q[b+1]); end
            if (ev_q[b+2][16:8] !== 9'h007) begin errors++; $display("FAIL miss_ev2: got %h want read of 07", ev_q[b+2]); end
        end
        read(8'd7, d, lat);
        checks += 2;
        if (d !== 8'd77) begin errors++; $display("FAIL miss_empty_data: got %0d want 77", d); end
        if (lat != 2) begin errors++; $display("FAIL miss_latency: got %0d want 2 after accept", lat); end
    endtask

    task automatic test_reset_mid();
        int b, v0;
        dn_ready = 1'b0;
        send(1'b1, 8'd3, 8'd5); send(1'b1, 8'd4, 8'd6);
        up_valid = 1'b1; up_we = 1'b0; up_addr = 8'd20;
        @(negedge clk);
        up_valid = 1'b0;
        checks++;
        if (dn_valid !== 1'b1) begin errors++; $display("FAIL rstmid_draining: dn_valid got %b want 1", dn_valid); end
        b = ev_q.size();
        v0 = vcnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks += 2;
        if (up_ready !== 1'b1) begin errors++; $display("FAIL rstmid_up_ready: got %b want 1", up_ready); end
        if (dn_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dn_valid: got %b want 0", dn_valid); end
        dn_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks += 2;
        if (ev_q.size() != b) begin errors++; $display("FAIL rstmid_dn_events: got %0d want 0", ev_q.size() - b); end
        if (vcnt != v0) begin errors++; $display("FAIL rstmid_up_do_valid: got %0d pulses want 0", vcnt - v0); end
    endtask

    task automatic test_random();
        logic [7:0] ref_mem [256];
        logic [16:0] exp_w [$];
        logic [16:0] got_w [$];
        logic [7:0] a, d, got;
        int lat, b, bad;
        bit stop;
        wait_drain();
        @(negedge clk);
        for (int i = 0; i < 256; i++) ref_mem[i] = arr[i];
        b = ev_q.size();
        stop = 1'b0;
        fork
            begin
                while (!stop) begin
                    @(negedge clk);
                    dn_ready = $urandom_range(0, 3) != 0;
                end
            end
            begin
                for (int n = 0; n < 200; n++) begin
                    a = 8'($urandom_range(0, 7));
                    d = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) begin
                        send(1'b1, a, d);
                        ref_mem[a] = d;
                        exp_w.push_back({1'b1, a, d});
                    end else begin
                        read(a, got, lat);
                        checks++;
                        if (got !== ref_mem[a]) begin errors++; $display("FAIL rand_read addr %0d: got %0d want %0d", a, got, ref_mem[a]); end
                    end
                end
                stop = 1'b1;
            end
        join
        wait_drain();
        @(negedge clk);
        for (int i = b; i < ev_q.size(); i++) if (ev_q[i][16]) got_w.push_back(ev_q[i]);
        checks++;
        if (got_w.size() != exp_w.size()) begin errors++; $display("FAIL rand_write_count: got %0d want %0d", got_w.size(), exp_w.size()); end
        bad = 0;
        for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) if (got_w[i] !== exp_w[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_write_order: got %0d misordered want 0", bad); end
        bad = 0;
        for (int i = 0; i < 8; i++) if (arr[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rand_array: got %0d wrong cells want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_drain_order();
        test_read_hit();
        test_newest();
        test_full();
        test_miss_drain();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
